// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit
//   Operand-forwarding and hazard-detection unit for the in-order core.
//   A shadow pipe of destination tags follows the DEPTH stages after ID
//   (stage 1 = EXE, 2 = MEM, 3 = WB with the default DEPTH). For each ID
//   source it picks the youngest in-flight producer, or the register file.
//   It stalls when that producer's data is not available yet: a load that
//   has not reached LOAD_STAGE, or any in-flight match when forwarding is off.
//
// Optional build macro: HAZARD_STATS_EN adds stall_cycles / fwd_hits counters.
//
// Ports
//   clk           in   clock, rising edge
//   rst           in   synchronous, active-high reset
//   fwd_en        in   0 = forwarding disabled, stall on any in-flight match
//   id_valid      in   valid instruction in ID
//   id_src        in   source regs, src i = [i*REG_AW +: REG_AW]
//   id_src_used   in   bit i = source i is actually read
//   id_dest       in   destination reg of the ID instruction
//   id_wb_en      in   ID instruction writes id_dest
//   id_is_load    in   ID instruction is a load
//   flush         in   branch-taken kill of the ID instruction
//   stall         out  hold IF/ID, insert a bubble into EXE
//   sel           out  per source: 0 = regfile, k = forward from stage k
//   stall_cycles  out  (HAZARD_STATS_EN) saturating count of stalled cycles
//   fwd_hits      out  (HAZARD_STATS_EN) saturating count of forwarded issues

module fwd_hazard_unit #(
    parameter int REG_AW     = 4,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    localparam int SEL_W     = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fwd_en,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [NUM_SRC-1:0]        id_src_used,
    input  logic [REG_AW-1:0]         id_dest,
    input  logic                      id_wb_en,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*SEL_W-1:0]  sel
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]               stall_cycles,
    output logic [31:0]               fwd_hits
`endif
);

    // Tag pipe: index k-1 holds stage k.
    logic [DEPTH-1:0]  vld_q, vld_d;
    logic [DEPTH-1:0]  wb_en_q, wb_en_d;
    logic [DEPTH-1:0]  is_load_q, is_load_d;
    logic [REG_AW-1:0] dest_q [DEPTH];
    logic [REG_AW-1:0] dest_d [DEPTH];

    logic [DEPTH-1:0]  match [NUM_SRC];
    int                ystage [NUM_SRC];
    logic              yload [NUM_SRC];
    logic [NUM_SRC-1:0] haz;
    logic              insert;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            match[i]  = '0;
            ystage[i] = 0;
            yload[i]  = 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                match[i][k] = id_valid && id_src_used[i] && vld_q[k] && wb_en_q[k]
                              && (dest_q[k] == id_src[i*REG_AW +: REG_AW]);
            end
            // Walk oldest to youngest so the lowest matching stage wins.
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (match[i][k]) begin
                    ystage[i] = k + 1;
                    yload[i]  = is_load_q[k];
                end
            end
        end
    end

    always_comb begin
        haz = '0;
        sel = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (fwd_en) begin
                sel[i*SEL_W +: SEL_W] = SEL_W'(ystage[i]);
                haz[i] = (ystage[i] != 0) && yload[i] && (ystage[i] < LOAD_STAGE);
            end else begin
                haz[i] = |match[i];
            end
        end
        stall = (|haz) && !flush;
    end

    // The pipe always advances; a stall or flush only turns the insert into a bubble.
    assign insert = id_valid && !stall && !flush;

    always_comb begin
        vld_d[0]     = insert;
        wb_en_d[0]   = id_wb_en;
        is_load_d[0] = id_is_load;
        dest_d[0]    = id_dest;
        for (int k = 1; k < DEPTH; k++) begin
            vld_d[k]     = vld_q[k-1];
            wb_en_d[k]   = wb_en_q[k-1];
            is_load_d[k] = is_load_q[k-1];
            dest_d[k]    = dest_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            wb_en_q   <= '0;
            is_load_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dest_q[k] <= '0;
            end
        end else begin
            vld_q     <= vld_d;
            wb_en_q   <= wb_en_d;
            is_load_q <= is_load_d;
            for (int k = 0; k < DEPTH; k++) begin
                dest_q[k] <= dest_d[k];
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] fwd_hits_q, fwd_hits_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        fwd_hits_d     = fwd_hits_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (id_valid && !stall && (|sel) && (fwd_hits_q != 32'hFFFF_FFFF)) begin
            fwd_hits_d = fwd_hits_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
            fwd_hits_q     <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            fwd_hits_q     <= fwd_hits_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign fwd_hits     = fwd_hits_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic       fwd_en;
    logic       id_valid;
    logic [7:0] id_src;
    logic [1:0] id_src_used;
    logic [3:0] id_dest;
    logic       id_wb_en;
    logic       id_is_load;
    logic       flush;
    logic       stall;
    logic [3:0] sel;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fwd_hazard_unit #(
        .REG_AW(4), .NUM_SRC(2), .DEPTH(3), .LOAD_STAGE(2)
    ) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid),
        .id_src(id_src), .id_src_used(id_src_used), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_is_load(id_is_load), .flush(flush),
        .stall(stall), .sel(sel)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s0,
                         input logic [1:0] used, input logic [3:0] dest,
                         input logic wb, input logic ld, input logic fl);
        id_valid    = v;
        id_src      = {s1, s0};
        id_src_used = used;
        id_dest     = dest;
        id_wb_en    = wb;
        id_is_load  = ld;
        flush       = fl;
        #3;
    endtask

    task automatic drain();
        for (int n = 0; n < 3; n++) begin
            nxt();
            drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        rst    = 1'b1;
        fwd_en = 1'b1;
        drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);

        // Reset with random ID inputs, then a random issue into an empty pipe
        nxt();
        drive(1'b1, 4'($urandom), 4'($urandom), 2'b11, 4'($urandom), 1'b1, 1'($urandom), 1'b0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_sel", {28'd0, sel}, 32'd0);
        nxt();
        rst = 1'b0;
        drive(1'b1, 4'($urandom), 4'($urandom), 2'b11, 4'($urandom), 1'b1, 1'($urandom), 1'b0);
        chk("post_rst_stall", {31'd0, stall}, 32'd0);
        chk("post_rst_sel", {28'd0, sel}, 32'd0);
        drain();

        // ADD wr r3, consumer src0=r3 walks through stages 1..3
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd3, 1'b1, 1'b0, 1'b0);
        nxt(); drive(1'b1, 4'd0, 4'd3, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("walk_c1_sel", {28'd0, sel}, 32'h1);
        nxt(); drive(1'b1, 4'd0, 4'd3, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("walk_c2_sel", {28'd0, sel}, 32'h2);
        nxt(); drive(1'b1, 4'd0, 4'd3, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("walk_c3_sel", {28'd0, sel}, 32'h3);
        chk("walk_c3_stall", {31'd0, stall}, 32'd0);
        nxt(); drive(1'b1, 4'd0, 4'd3, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("walk_c4_sel", {28'd0, sel}, 32'h0);
        drain();

        // Two writers of r5: youngest wins on src1
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b0, 1'b0);
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd5, 1'b1, 1'b0, 1'b0);
        nxt(); drive(1'b1, 4'd5, 4'd0, 2'b10, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("youngest_sel", {28'd0, sel}, 32'h4);
        chk("youngest_stall", {31'd0, stall}, 32'd0);
        drain();

        // LDR wr r2: load-use stall, then forward from MEM
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1, 1'b0);
        nxt(); drive(1'b1, 4'd2, 4'd0, 2'b10, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("ldu_c1_stall", {31'd0, stall}, 32'd1);
        nxt(); drive(1'b1, 4'd2, 4'd0, 2'b10, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("ldu_c2_stall", {31'd0, stall}, 32'd0);
        chk("ldu_c2_sel", {28'd0, sel}, 32'h8);
        drain();

        // Load-use on an unused source never hazards; id_valid=0 never stalls
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1, 1'b0);
        nxt(); drive(1'b1, 4'd0, 4'd2, 2'b10, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("unused_src_stall", {31'd0, stall}, 32'd0);
        chk("unused_src_sel", {28'd0, sel}, 32'h0);
        drive(1'b0, 4'd0, 4'd2, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("invalid_id_stall", {31'd0, stall}, 32'd0);
        drain();

        // Forwarding off: stall across all three stages
        fwd_en = 1'b0;
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 1'b0, 1'b0);
        nxt(); drive(1'b1, 4'd0, 4'd7, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("nofwd_c1_stall", {31'd0, stall}, 32'd1);
        nxt(); drive(1'b1, 4'd0, 4'd7, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("nofwd_c2_stall", {31'd0, stall}, 32'd1);
        nxt(); drive(1'b1, 4'd0, 4'd7, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("nofwd_c3_stall", {31'd0, stall}, 32'd1);
        nxt(); drive(1'b1, 4'd0, 4'd7, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("nofwd_c4_stall", {31'd0, stall}, 32'd0);
        chk("nofwd_c4_sel", {28'd0, sel}, 32'h0);
        fwd_en = 1'b1;
        drain();

        // Flushed writer of r4 is never inserted
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 1'b0, 1'b1);
        nxt(); drive(1'b1, 4'd0, 4'd4, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("flush_sel", {28'd0, sel}, 32'h0);
        chk("flush_stall", {31'd0, stall}, 32'd0);
        drain();

        // Flush beats a load-use stall; flushed consumer leaves a bubble
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 1'b1, 1'b0);
        nxt(); drive(1'b1, 4'd0, 4'd2, 2'b01, 4'd2, 1'b1, 1'b0, 1'b1);
        chk("flush_wins_stall", {31'd0, stall}, 32'd0);
        nxt(); drive(1'b1, 4'd0, 4'd2, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("after_flush_sel", {28'd0, sel}, 32'h2);
        chk("after_flush_stall", {31'd0, stall}, 32'd0);
        drain();

        // Own destination as source sees only older stages; two sources at once
        nxt(); drive(1'b1, 4'd0, 4'd6, 2'b01, 4'd6, 1'b1, 1'b0, 1'b0);
        chk("self_dest_sel", {28'd0, sel}, 32'h0);
        drain();
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd1, 1'b1, 1'b0, 1'b0);
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd8, 1'b1, 1'b0, 1'b0);
        nxt(); drive(1'b1, 4'd8, 4'd1, 2'b11, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("two_src_sel", {28'd0, sel}, 32'h6);
        drain();

        // Reset mid-operation discards in-flight tags
        nxt(); drive(1'b1, 4'd0, 4'd0, 2'b00, 4'd9, 1'b1, 1'b0, 1'b0);
        nxt(); rst = 1'b1; drive(1'b0, 4'd0, 4'd0, 2'b00, 4'd0, 1'b0, 1'b0, 1'b0);
        nxt(); rst = 1'b0; drive(1'b1, 4'd0, 4'd9, 2'b01, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("mid_rst_sel", {28'd0, sel}, 32'h0);
        chk("mid_rst_stall", {31'd0, stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
